// File: rtl/lfm_sweep_sequencer_if.sv
// Phase-increment channel between the LFM sweep sequencer (master) and the DDS
// compiler s_axis_phase port (slave).
`timescale 1ns/1ps
interface lfm_sweep_sequencer_if #(
  parameter int PINC_W = 32
);
  logic              pinc_tvalid;
  logic              pinc_tready;
  logic [PINC_W-1:0] pinc_tdata;

  modport master (output pinc_tvalid, output pinc_tdata, input pinc_tready);
  modport slave  (input pinc_tvalid, input pinc_tdata, output pinc_tready);
endinterface

// File: rtl/lfm_sweep_sequencer.sv
// Stepped LFM sweep sequencer driving the DDS phase-increment channel.
// Optional macro LFM_SEQ_CLAMP_EN: saturating pinc arithmetic instead of modulo wrap.
`timescale 1ns/1ps
module lfm_sweep_sequencer #(
  parameter int PINC_W  = 32,
  parameter int DWELL_W = 21,
  parameter int STEP_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PINC_W-1:0]    cfg_start_pinc,
  input  logic [PINC_W-1:0]    cfg_step,
  input  logic [STEP_W-1:0]    cfg_nsteps,
  input  logic [DWELL_W-1:0]   cfg_dwell,
  input  logic [1:0]           cfg_mode,
  input  logic                 cfg_repeat,
  input  logic                 dds_sample_valid,
  lfm_sweep_sequencer_if.master pinc,
  output logic                 busy,
  output logic                 done,
  output logic [STEP_W:0]      step_idx
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DWELL} state_t;

  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;

  state_t               state_q, state_d;
  logic                 tvalid_q, tvalid_d;
  logic [PINC_W-1:0]    pinc_q, pinc_d;
  logic [STEP_W:0]      step_idx_q, step_idx_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [PINC_W-1:0]    start_pinc_q, start_pinc_d;
  logic [PINC_W-1:0]    step_q, step_d;
  logic [STEP_W-1:0]    nsteps_q, nsteps_d;
  logic [DWELL_W-1:0]   dwell_max_q, dwell_max_d;
  logic [1:0]           mode_q, mode_d;
  logic                 repeat_q, repeat_d;

  logic [PINC_W:0]      sum_w;
  logic [PINC_W-1:0]    add_res;
  logic [PINC_W-1:0]    sub_res;
  logic [STEP_W:0]      last_idx;
  logic                 dir_up;

  assign sum_w = {1'b0, pinc_q} + {1'b0, step_q};

`ifdef LFM_SEQ_CLAMP_EN
  assign add_res = sum_w[PINC_W] ? '1 : sum_w[PINC_W-1:0];
  assign sub_res = (pinc_q < step_q) ? '0 : (pinc_q - step_q);
`else
  assign add_res = sum_w[PINC_W-1:0];
  assign sub_res = pinc_q - step_q;
`endif

  // Triangle ramps up for the first nsteps transitions, then folds back down.
  always_comb begin
    last_idx = {1'b0, nsteps_q};
    dir_up   = 1'b1;
    if (mode_q == MODE_TRI) begin
      last_idx = {nsteps_q, 1'b0};
      dir_up   = (step_idx_q < {1'b0, nsteps_q});
    end else if (mode_q == MODE_DOWN) begin
      dir_up   = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    tvalid_d     = tvalid_q;
    pinc_d       = pinc_q;
    step_idx_d   = step_idx_q;
    dwell_cnt_d  = dwell_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    start_pinc_d = start_pinc_q;
    step_d       = step_q;
    nsteps_d     = nsteps_q;
    dwell_max_d  = dwell_max_q;
    mode_d       = mode_q;
    repeat_d     = repeat_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_pinc_d = cfg_start_pinc;
          step_d       = cfg_step;
          nsteps_d     = cfg_nsteps;
          dwell_max_d  = (cfg_dwell == '0) ? '0 : (cfg_dwell - 1'b1);
          mode_d       = cfg_mode;
          repeat_d     = cfg_repeat;
          pinc_d       = cfg_start_pinc;
          step_idx_d   = '0;
          state_d      = S_SEND;
          tvalid_d     = 1'b1;
          busy_d       = 1'b1;
        end
      end
      S_SEND: begin
        if (pinc.pinc_tready) begin
          state_d     = S_DWELL;
          tvalid_d    = 1'b0;
          dwell_cnt_d = '0;
        end
      end
      S_DWELL: begin
        if (dds_sample_valid) begin
          if (dwell_cnt_q == dwell_max_q) begin
            if (step_idx_q != last_idx) begin
              step_idx_d = step_idx_q + 1'b1;
              pinc_d     = dir_up ? add_res : sub_res;
              state_d    = S_SEND;
              tvalid_d   = 1'b1;
            end else if (repeat_q) begin
              step_idx_d = '0;
              pinc_d     = start_pinc_q;
              state_d    = S_SEND;
              tvalid_d   = 1'b1;
            end else begin
              done_d     = 1'b1;
              state_d    = S_IDLE;
              busy_d     = 1'b0;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

    // Abort wins over everything, including a start in the same cycle.
    if (abort) begin
      state_d  = S_IDLE;
      tvalid_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      tvalid_q     <= 1'b0;
      pinc_q       <= '0;
      step_idx_q   <= '0;
      dwell_cnt_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_pinc_q <= '0;
      step_q       <= '0;
      nsteps_q     <= '0;
      dwell_max_q  <= '0;
      mode_q       <= '0;
      repeat_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tvalid_q     <= tvalid_d;
      pinc_q       <= pinc_d;
      step_idx_q   <= step_idx_d;
      dwell_cnt_q  <= dwell_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_pinc_q <= start_pinc_d;
      step_q       <= step_d;
      nsteps_q     <= nsteps_d;
      dwell_max_q  <= dwell_max_d;
      mode_q       <= mode_d;
      repeat_q     <= repeat_d;
    end
  end

  assign pinc.pinc_tvalid = tvalid_q;
  assign pinc.pinc_tdata  = pinc_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign step_idx         = step_idx_q;

endmodule

// File: tb/tb_lfm_sweep_sequencer.sv
// Scoreboard bench for lfm_sweep_sequencer: expected beats are queued per sweep
// from an arithmetic reference model and popped by a negedge monitor on each handshake.
`timescale 1ns/1ps
module tb_lfm_sweep_sequencer;
  localparam int PW = 32;
  localparam int DW = 21;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] cfg_start_pinc = '0;
  logic [PW-1:0] cfg_step = '0;
  logic [SW-1:0] cfg_nsteps = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [1:0]    cfg_mode = '0;
  logic          cfg_repeat = 1'b0;
  logic          dds_sample_valid = 1'b0;
  logic          busy, done;
  logic [SW:0]   step_idx;

  always #5 clk = ~clk;

  lfm_sweep_sequencer_if #(.PINC_W(PW)) pif ();

  lfm_sweep_sequencer #(.PINC_W(PW), .DWELL_W(DW), .STEP_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_start_pinc(cfg_start_pinc), .cfg_step(cfg_step), .cfg_nsteps(cfg_nsteps),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_repeat(cfg_repeat),
    .dds_sample_valid(dds_sample_valid), .pinc(pif),
    .busy(busy), .done(done), .step_idx(step_idx)
  );

  typedef struct {
    longint pinc;
    int     idx;
  } beat_t;

  beat_t  exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     exp_dwell = 1;
  int     done_seen = 0;
  int     hs_seen = 0;
  int     ready_pct = 100;
  int     valid_pct = 100;
  bit     force_ready_low = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: frequency list from sweep rules with 64-bit arithmetic then wrap or clamp.
  task automatic push_sweep(input longint sp, input longint st, input int ns,
                            input int mode, input int reps);
    int     nf;
    longint v;
    bit     up;
    nf = (mode == 2) ? 2 * ns + 1 : ns + 1;
    for (int r = 0; r < reps; r++) begin
      v = sp;
      for (int i = 0; i < nf; i++) begin
        beat_t b;
        b.pinc = v;
        b.idx  = i;
        exp_q.push_back(b);
        up = (mode == 1) ? 1'b0 : ((mode == 2) ? (i < ns) : 1'b1);
        if (up) begin
          v = v + st;
`ifdef LFM_SEQ_CLAMP_EN
          if (v > 64'hFFFF_FFFF) v = 64'hFFFF_FFFF;
`else
          v = v & 64'hFFFF_FFFF;
`endif
        end else begin
          v = v - st;
`ifdef LFM_SEQ_CLAMP_EN
          if (v < 0) v = 0;
`else
          v = v & 64'hFFFF_FFFF;
`endif
        end
      end
    end
  endtask

  // Handshake inputs randomised each cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    pif.pinc_tready  = force_ready_low ? 1'b0 : ($urandom_range(99) < ready_pct);
    dds_sample_valid = ($urandom_range(99) < valid_pct);
  end

  // Monitor: sees at each negedge the values the DUT will act on at the next edge.
  bit     in_dwell = 1'b0;
  int     dcnt = 0;
  bit     prev_hold = 1'b0;
  bit     prev_done = 1'b0;
  longint prev_data = 0;
  longint last_pinc = 0;

  always @(negedge clk) begin
    if (!reset) begin
      in_dwell  = 1'b0;
      prev_hold = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_tvalid", pif.pinc_tvalid, 1);
        chk("hold_tdata", pif.pinc_tdata, prev_data);
      end
      if (in_dwell && (pif.pinc_tvalid || done)) begin
        chk("dwell_len", dcnt, exp_dwell);
        in_dwell = 1'b0;
      end
      if (done) begin
        chk("done_busy_low", busy, 0);
        chk("done_single_pulse", prev_done, 0);
        chk("done_all_beats", exp_q.size(), 0);
        chk("idle_tdata_hold", pif.pinc_tdata, last_pinc);
        done_seen++;
      end
      prev_done = done;
      if (in_dwell && dds_sample_valid) dcnt++;
      if (abort) begin
        in_dwell  = 1'b0;
        prev_hold = 1'b0;
      end else begin
        prev_hold = pif.pinc_tvalid && !pif.pinc_tready;
        prev_data = pif.pinc_tdata;
        if (pif.pinc_tvalid && pif.pinc_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", pif.pinc_tdata, -1);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_pinc", pif.pinc_tdata, e.pinc);
            chk("beat_step_idx", step_idx, e.idx);
            last_pinc = e.pinc;
          end
          hs_seen++;
          in_dwell = 1'b1;
          dcnt     = 0;
        end
      end
    end
  end

  task automatic run_sweep(input logic [PW-1:0] sp, input logic [PW-1:0] st,
                           input int ns, input int dwell, input int mode,
                           input bit rep, input int abort_after, input int hold);
    int d0, h0, c, pm;
    pm = (mode == 3) ? 0 : mode;
    exp_q.delete();
    exp_dwell = (dwell == 0) ? 1 : dwell;
    push_sweep(longint'(sp), longint'(st), ns, pm, rep ? 8 : 1);
    d0 = done_seen;
    h0 = hs_seen;
    if (hold > 0) force_ready_low = 1'b1;
    @(posedge clk); #1;
    cfg_start_pinc = sp;
    cfg_step       = st;
    cfg_nsteps     = SW'(ns);
    cfg_dwell      = DW'(dwell);
    cfg_mode       = 2'(mode);
    cfg_repeat     = rep;
    start          = 1'b1;
    @(posedge clk); #1;
    start          = 1'b0;
    cfg_start_pinc = $urandom;
    cfg_step       = $urandom;
    cfg_nsteps     = SW'($urandom_range(255));
    cfg_dwell      = DW'($urandom_range(7));
    cfg_mode       = 2'($urandom_range(3));
    cfg_repeat     = 1'($urandom_range(1));
    chk("busy_after_start", busy, 1);
    chk("tvalid_after_start", pif.pinc_tvalid, 1);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 force_ready_low = 1'b0;
    end
    if (!rep) begin
      c = 0;
      while (done_seen == d0 && c < 20000) begin
        @(posedge clk);
        c++;
      end
      chk("sweep_done_count", done_seen - d0, 1);
    end else begin
      c = 0;
      while (hs_seen < h0 + abort_after && c < 20000) begin
        @(posedge clk);
        c++;
      end
      chk("repeat_beats_reached", (hs_seen >= h0 + abort_after), 1);
      repeat ($urandom_range(3)) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_tvalid", pif.pinc_tvalid, 0);
      repeat (4) @(posedge clk);
      #1 chk("abort_no_done", done_seen - d0, 0);
      exp_q.delete();
    end
    @(posedge clk);
  endtask

  initial begin
    #2;
    chk("rst_tvalid", pif.pinc_tvalid, 0);
    chk("rst_tdata", pif.pinc_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step_idx", step_idx, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);

    // Directed: up sweep, triangle, backpressure with dwell gaps, abort, wrap.
    run_sweep(32'h1999999A, 32'h028F5C29, 3, 4, 0, 1'b0, 0, 0);
    run_sweep(32'h1999999A, 32'h028F5C29, 3, 4, 2, 1'b0, 0, 0);
    valid_pct = 50;
    run_sweep(32'h1999999A, 32'h028F5C29, 3, 4, 0, 1'b0, 0, 5);
    valid_pct = 100;
    run_sweep(32'h1999999A, 32'h028F5C29, 3, 4, 0, 1'b1, 6, 0);
    run_sweep(32'h1999999A, 32'h028F5C29, 3, 4, 1, 1'b0, 0, 0);
    run_sweep(32'hFFFFFFF0, 32'h00000020, 1, 2, 0, 1'b0, 0, 0);
    run_sweep(32'h00000010, 32'h00000020, 1, 2, 1, 1'b0, 0, 0);

    // Reset while holding in SEND: outputs clear asynchronously.
    force_ready_low = 1'b1;
    @(posedge clk); #1;
    cfg_start_pinc = 32'h12345678;
    cfg_nsteps     = 8'd2;
    cfg_dwell      = 21'd3;
    cfg_mode       = 2'd0;
    cfg_repeat     = 1'b0;
    start          = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("midsend_rst_tvalid", pif.pinc_tvalid, 0);
    chk("midsend_rst_tdata", pif.pinc_tdata, 0);
    chk("midsend_rst_busy", busy, 0);
    chk("midsend_rst_step_idx", step_idx, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    force_ready_low = 1'b0;
    exp_q.delete();
    @(posedge clk);

    // Zero dwell behaves as one sample.
    run_sweep(32'h00001000, 32'h00000100, 2, 0, 2, 1'b0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      int ns_r, dw_r, md_r, rp_r;
      ready_pct = $urandom_range(40, 100);
      valid_pct = $urandom_range(30, 100);
      ns_r = $urandom_range(4);
      dw_r = $urandom_range(5);
      md_r = $urandom_range(3);
      rp_r = ($urandom_range(3) == 0) ? 1 : 0;
      run_sweep($urandom, $urandom, ns_r, dw_r, md_r, 1'(rp_r),
                $urandom_range(1, ns_r + 3), ($urandom_range(3) == 0) ? 3 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
